// File: rtl/usb_ft245_tx_fifo.sv
// FT245-style byte transmitter: queues measurement words in a FIFO and writes them to the
// USB FIFO chip byte by byte, with an optional framing header before each word.
module usb_ft245_tx_fifo #(
    parameter int unsigned WORD_BYTES    = 4,
    parameter int unsigned DEPTH_LOG2    = 4,
    parameter int unsigned SETUP_TICKS   = 1,
    parameter int unsigned WR_LOW_TICKS  = 2,
    parameter int unsigned WR_HIGH_TICKS = 2,
    parameter bit          LSB_FIRST     = 1'b1,
    parameter bit          HEADER_EN     = 1'b0,
    parameter logic [7:0]  HEADER_BYTE   = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*WORD_BYTES-1:0] data_in,
    input  logic                    push,
    output logic                    full,
    output logic [DEPTH_LOG2:0]     level,
    output logic [15:0]             overflow,
    input  logic                    txe,
    output logic                    wr,
    output logic                    rd,
    output logic [7:0]              data_out,
    output logic                    data_oe,
    output logic                    busy
);

    localparam int unsigned DW        = 8 * WORD_BYTES;
    localparam int unsigned DEPTH     = 2 ** DEPTH_LOG2;
    localparam int unsigned NBYTES    = WORD_BYTES + (HEADER_EN ? 1 : 0);
    localparam int unsigned MAX_A     = (SETUP_TICKS > WR_LOW_TICKS) ? SETUP_TICKS : WR_LOW_TICKS;
    localparam int unsigned MAX_TICKS = (MAX_A > WR_HIGH_TICKS) ? MAX_A : WR_HIGH_TICKS;
    localparam int unsigned CW        = $clog2(MAX_TICKS + 1);
    localparam int unsigned IW        = $clog2(WORD_BYTES + 2);

    localparam logic [CW-1:0]         SETUP_LAST = CW'(SETUP_TICKS - 1);
    localparam logic [CW-1:0]         LOW_LAST   = CW'(WR_LOW_TICKS - 1);
    localparam logic [CW-1:0]         HIGH_LAST  = CW'(WR_HIGH_TICKS - 1);
    localparam logic [IW-1:0]         LAST_IDX   = IW'(NBYTES - 1);
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSetup,
        StStrobe,
        StHold
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DW-1:0]         word;
    logic [DW-1:0]         word_next;

    logic [DW-1:0]         mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  push_ok;
    logic                  pop;

    logic                  txe_m;
    logic                  txe_s;

    function automatic logic [7:0] head_byte(input logic [DW-1:0] w);
        return LSB_FIRST ? w[7:0] : w[DW-1 -: 8];
    endfunction

    // Full is taken from the registered level, so a push coinciding with a pop at full is dropped.
    assign full    = (level == FULL_LEVEL);
    assign push_ok = push && !full;
    assign pop     = (state == StLoad);
    assign busy    = (state != StIdle) || (level != '0);
    assign rd      = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            txe_m <= 1'b1;
            txe_s <= 1'b1;
        end else begin
            txe_m <= txe;
            txe_s <= txe_m;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
            if (push && full && (overflow != 16'hFFFF)) begin
                overflow <= overflow + 16'd1;
            end
        end
    end

    // The header slot does not consume word bits, so the shift is skipped after it.
    always_comb begin
        word_next = word;
        if (!(HEADER_EN && (idx == '0))) begin
            word_next = LSB_FIRST ? (word >> 8) : (word << 8);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            cnt      <= '0;
            idx      <= '0;
            word     <= '0;
            wr       <= 1'b1;
            data_out <= 8'h00;
            data_oe  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (level != '0) begin
                        state <= StLoad;
                    end
                end
                StLoad: begin
                    word     <= mem[rptr];
                    idx      <= '0;
                    cnt      <= '0;
                    data_oe  <= 1'b1;
                    data_out <= HEADER_EN ? HEADER_BYTE : head_byte(mem[rptr]);
                    state    <= StSetup;
                end
                StSetup: begin
                    if (txe_s) begin
                        cnt <= '0;
                    end else if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        wr    <= 1'b0;
                        state <= StStrobe;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StStrobe: begin
                    if (cnt == LOW_LAST) begin
                        cnt   <= '0;
                        wr    <= 1'b1;
                        state <= StHold;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StHold: begin
                    if (cnt == HIGH_LAST) begin
                        cnt <= '0;
                        if (idx != LAST_IDX) begin
                            idx      <= idx + 1'b1;
                            word     <= word_next;
                            data_out <= head_byte(word_next);
                            state    <= StSetup;
                        end else if (level != '0) begin
                            state <= StLoad;
                        end else begin
                            data_oe <= 1'b0;
                            state   <= StIdle;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_ft245_tx_fifo.sv
// Bench for usb_ft245_tx_fifo: two configurations, byte scoreboards fed from a word-level model,
// cycle checks derived from the documented latencies.
module tb_usb_ft245_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: defaults (LSB first, no header, depth 16)
    logic        rst_a, push_a, txe_a;
    logic [31:0] din_a;
    logic        full_a, wr_a, rd_a, oe_a, busy_a;
    logic [4:0]  level_a;
    logic [15:0] ovf_a;
    logic [7:0]  dout_a;

    // Instance B: MSB first, header on, depth 4
    logic        rst_b, push_b, txe_b;
    logic [31:0] din_b;
    logic        full_b, wr_b, rd_b, oe_b, busy_b;
    logic [2:0]  level_b;
    logic [15:0] ovf_b;
    logic [7:0]  dout_b;

    usb_ft245_tx_fifo dut_a (
        .clk(clk), .rst(rst_a), .data_in(din_a), .push(push_a), .full(full_a),
        .level(level_a), .overflow(ovf_a), .txe(txe_a), .wr(wr_a), .rd(rd_a),
        .data_out(dout_a), .data_oe(oe_a), .busy(busy_a)
    );

    usb_ft245_tx_fifo #(
        .DEPTH_LOG2(2), .LSB_FIRST(1'b0), .HEADER_EN(1'b1), .HEADER_BYTE(8'hA5)
    ) dut_b (
        .clk(clk), .rst(rst_b), .data_in(din_b), .push(push_b), .full(full_b),
        .level(level_b), .overflow(ovf_b), .txe(txe_b), .wr(wr_b), .rd(rd_b),
        .data_out(dout_b), .data_oe(oe_b), .busy(busy_b)
    );

    logic [7:0]  q_a[$];
    logic [7:0]  q_b[$];
    int unsigned fall_a[$];
    int          pulses_b = 0;
    logic        prev_wr_a = 1'b1, prev_wr_b = 1'b1;
    logic [7:0]  held_a, held_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: a word becomes [header] + its bytes in the configured order.
    task automatic model_word(input bit is_b, input logic [31:0] w);
        if (is_b) q_b.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            int         k;
            logic [7:0] bt;
            k  = is_b ? 3 - i : i;
            bt = 8'(w >> (8 * k));
            if (is_b) q_b.push_back(bt);
            else q_a.push_back(bt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a(input int max_cycles);
        int t = 0;
        while (busy_a && t < max_cycles) begin
            step();
            t++;
        end
        check("a_idle_within_budget", busy_a, 1'b0);
    endtask

    task automatic wait_idle_b(input int max_cycles);
        int t = 0;
        while (busy_b && t < max_cycles) begin
            step();
            t++;
        end
        check("b_idle_within_budget", busy_b, 1'b0);
    endtask

    // Monitors: every wr falling edge presents one byte to the scoreboard.
    always @(negedge clk) begin
        if (prev_wr_a === 1'b1 && wr_a === 1'b0) begin
            fall_a.push_back(cyc);
            held_a = dout_a;
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_byte: got %0h, expected no byte", dout_a);
            end else begin
                check("a_byte", dout_a, q_a.pop_front());
            end
            check("a_oe_at_strobe", oe_a, 1'b1);
        end else if (wr_a === 1'b0) begin
            check("a_data_hold", dout_a, held_a);
        end
        prev_wr_a = wr_a;
    end

    always @(negedge clk) begin
        if (prev_wr_b === 1'b1 && wr_b === 1'b0) begin
            pulses_b++;
            held_b = dout_b;
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_byte: got %0h, expected no byte", dout_b);
            end else begin
                check("b_byte", dout_b, q_b.pop_front());
            end
            check("b_oe_at_strobe", oe_b, 1'b1);
        end else if (wr_b === 1'b0) begin
            check("b_data_hold", dout_b, held_b);
        end
        prev_wr_b = wr_b;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n, k;
        int unsigned exp_f[4];
        logic [31:0] w;

        rst_a = 1'b1; push_a = 1'b0; txe_a = 1'b0; din_a = '0;
        rst_b = 1'b1; push_b = 1'b0; txe_b = 1'b0; din_b = '0;
        repeat (3) step();

        check("a_rst_wr", wr_a, 1'b1);
        check("a_rst_rd", rd_a, 1'b1);
        check("a_rst_data_out", dout_a, 8'h00);
        check("a_rst_oe", oe_a, 1'b0);
        check("a_rst_full", full_a, 1'b0);
        check("a_rst_level", level_a, 0);
        check("a_rst_overflow", ovf_a, 0);
        check("a_rst_busy", busy_a, 1'b0);
        check("b_rst_wr", wr_b, 1'b1);
        check("b_rst_rd", rd_b, 1'b1);
        check("b_rst_oe", oe_b, 1'b0);
        check("b_rst_level", level_b, 0);

        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (4) step();

        // Basic word, LSB first: falls at n+4+5i, bus released at n+23.
        fall_a.delete();
        din_a = 32'h11223344; push_a = 1'b1; n = cyc;
        model_word(1'b0, din_a);
        step();
        push_a = 1'b0;
        check("a_level_after_push", level_a, 1);
        repeat (21) step();
        check("a_oe_last_hold", oe_a, 1'b1);
        step();
        check("a_oe_after_word", oe_a, 1'b0);
        check("a_busy_after_word", busy_a, 1'b0);
        check("a_fall_count", fall_a.size(), 4);
        for (int i = 0; i < 4 && i < fall_a.size(); i++)
            check("a_fall_cycle", fall_a[i], n + 4 + 5 * i);
        check("a_queue_empty_t1", q_a.size(), 0);

        // txe stall for 10 cycles during the SETUP of byte 2.
        fall_a.delete();
        din_a = 32'hA1B2C3D4; push_a = 1'b1; n = cyc;
        model_word(1'b0, din_a);
        step();
        push_a = 1'b0;
        repeat (10) step();
        txe_a = 1'b1;
        repeat (7) step();
        check("a_stall_data", dout_a, 8'hB2);
        check("a_stall_wr", wr_a, 1'b1);
        check("a_stall_oe", oe_a, 1'b1);
        repeat (3) step();
        txe_a = 1'b0;
        repeat (12) step();
        check("a_busy_after_stall", busy_a, 1'b0);
        exp_f = '{n + 4, n + 9, n + 24, n + 29};
        check("a_stall_fall_count", fall_a.size(), 4);
        for (int i = 0; i < 4 && i < fall_a.size(); i++)
            check("a_stall_fall_cycle", fall_a[i], exp_f[i]);
        check("a_queue_empty_t4", q_a.size(), 0);

        // Reset during STROBE of the first byte, with two more words queued.
        for (int i = 0; i < 3; i++) begin
            din_a = 32'h0BAD0000 + i; push_a = 1'b1;
            if (i == 0) n = cyc;
            model_word(1'b0, din_a);
            step();
        end
        push_a = 1'b0;
        step();
        check("a_level_before_rst", level_a, 2);
        check("a_wr_low_before_rst", wr_a, 1'b0);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check("a_rst_mid_wr", wr_a, 1'b1);
        check("a_rst_mid_oe", oe_a, 1'b0);
        check("a_rst_mid_level", level_a, 0);
        check("a_rst_mid_busy", busy_a, 1'b0);
        q_a.delete();
        repeat (4) step();
        din_a = 32'hCAFEF00D; push_a = 1'b1;
        model_word(1'b0, din_a);
        step();
        push_a = 1'b0;
        wait_idle_a(100);
        check("a_queue_empty_t6", q_a.size(), 0);

        // Random words, random gaps, random txe; never more than 12 outstanding.
        for (int i = 0; i < 12; i++) begin
            din_a = $urandom; push_a = 1'b1;
            txe_a = ($urandom_range(0, 3) == 0);
            model_word(1'b0, din_a);
            step();
            push_a = 1'b0;
            k = $urandom_range(0, 3);
            for (int j = 0; j < int'(k); j++) begin
                txe_a = ($urandom_range(0, 3) == 0);
                step();
            end
        end
        txe_a = 1'b0;
        step();
        wait_idle_a(1000);
        check("a_queue_empty_rand", q_a.size(), 0);
        check("a_overflow_rand", ovf_a, 0);

        // Instance B: header + MSB first, exactly 5 pulses.
        pulses_b = 0;
        din_b = 32'hDEADBEEF; push_b = 1'b1;
        model_word(1'b1, din_b);
        step();
        push_b = 1'b0;
        repeat (27) step();
        check("b_busy_after_word", busy_b, 1'b0);
        check("b_oe_after_word", oe_b, 1'b0);
        check("b_pulse_count", pulses_b, 5);
        check("b_queue_empty_t2", q_b.size(), 0);

        // Push coinciding with pop at level 1 leaves level unchanged.
        din_b = 32'h01020304; push_b = 1'b1;
        model_word(1'b1, din_b);
        step();
        push_b = 1'b0;
        check("b_level_one", level_b, 1);
        step();
        din_b = 32'h05060708; push_b = 1'b1;
        model_word(1'b1, din_b);
        step();
        push_b = 1'b0;
        check("b_level_push_pop", level_b, 1);
        wait_idle_b(200);
        check("b_queue_empty_t5a", q_b.size(), 0);

        // Fill with txe high while the first word sits in SETUP.
        txe_b = 1'b1;
        repeat (4) step();
        w = 32'h10000000; din_b = w; push_b = 1'b1;
        model_word(1'b1, w);
        step();
        push_b = 1'b0;
        repeat (4) step();
        check("b_level_loaded", level_b, 0);
        check("b_busy_loaded", busy_b, 1'b1);
        for (int i = 0; i < 6; i++) begin
            din_b = 32'h20000000 + 32'(i) * 32'h01010101; push_b = 1'b1;
            if (i < 4) model_word(1'b1, din_b);
            step();
            check("b_fill_level", level_b, (i < 4) ? i + 1 : 4);
            check("b_fill_full", full_b, i >= 3);
        end
        push_b = 1'b0;
        check("b_overflow_fill", ovf_b, 2);
        check("b_wr_held_high", wr_b, 1'b1);

        // Release txe; the next LOAD falls 2 + 5*5 cycles later and meets a push at full.
        txe_b = 1'b0; k = cyc;
        repeat (27) step();
        din_b = 32'hFFFF0000; push_b = 1'b1;
        step();
        push_b = 1'b0;
        check("b_level_pop_at_full", level_b, 3);
        check("b_overflow_pop_at_full", ovf_b, 3);
        check("b_full_cleared", full_b, 1'b0);
        wait_idle_b(400);
        check("b_queue_empty_t3", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
